// File: rtl/inst_encoder_pkg.sv
// inst_encoder_pkg: LEGv8 op codes, opcode field constants and immediate range helper
package inst_encoder_pkg;

    localparam int INST_SIZE = 32;

    typedef enum logic [3:0] {
        ENC_OP_LDUR = 4'd0,
        ENC_OP_STUR = 4'd1,
        ENC_OP_ADD  = 4'd2,
        ENC_OP_SUB  = 4'd3,
        ENC_OP_AND  = 4'd4,
        ENC_OP_ORR  = 4'd5,
        ENC_OP_CBZ  = 4'd6,
        ENC_OP_B    = 4'd7
    } enc_op_e;

    localparam logic [10:0] OPC_ADD  = 11'h458;
    localparam logic [10:0] OPC_SUB  = 11'h658;
    localparam logic [10:0] OPC_AND  = 11'h450;
    localparam logic [10:0] OPC_ORR  = 11'h550;
    localparam logic [10:0] OPC_LDUR = 11'h7C2;
    localparam logic [10:0] OPC_STUR = 11'h7C0;
    localparam logic [7:0]  OPC_CBZ  = 8'hB4;
    localparam logic [5:0]  OPC_B    = 6'b000101;

    // True when imm fits a signed field whose sign bit is at position msb.
    function automatic logic fits(input logic [31:0] imm, input int unsigned msb);
        logic [31:0] hi;
        hi = $signed(imm) >>> msb;
        return (hi == '0) || (hi == '1);
    endfunction

endpackage

// File: rtl/inst_encoder_if.sv
// inst_encoder_if: descriptor input, encoded word output and error status of the encoder
interface inst_encoder_if import inst_encoder_pkg::*; #(parameter int ERR_CNT_W = 8);
    logic                  in_valid;
    logic                  in_ready;
    logic [3:0]            in_op;
    logic [4:0]            in_rd;
    logic [4:0]            in_rn;
    logic [4:0]            in_rm;
    logic [31:0]           in_imm;
    logic                  out_valid;
    logic                  out_ready;
    logic [INST_SIZE-1:0]  out_inst;
    logic [63:0]           out_addr;
    logic                  err_sticky;
    logic [ERR_CNT_W-1:0]  err_cnt;

    modport master (
        output in_valid, in_op, in_rd, in_rn, in_rm, in_imm, out_ready,
        input  in_ready, out_valid, out_inst, out_addr, err_sticky, err_cnt
    );

    modport slave (
        input  in_valid, in_op, in_rd, in_rn, in_rm, in_imm, out_ready,
        output in_ready, out_valid, out_inst, out_addr, err_sticky, err_cnt
    );
endinterface

// File: rtl/inst_field_pack.sv
// inst_field_pack: combinational LEGv8 field packing with immediate range check
module inst_field_pack import inst_encoder_pkg::*; (
    input  logic [3:0]           i_op,
    input  logic [4:0]           i_rd,
    input  logic [4:0]           i_rn,
    input  logic [4:0]           i_rm,
    input  logic [31:0]          i_imm,
    output logic [INST_SIZE-1:0] o_word,
    output logic                 o_range_err
);
    always_comb begin
        o_word      = '0;
        o_range_err = 1'b0;
        case (i_op)
            ENC_OP_LDUR, ENC_OP_STUR: begin
                o_word      = {i_op == ENC_OP_LDUR ? OPC_LDUR : OPC_STUR, i_imm[8:0], 2'b00, i_rn, i_rd};
                o_range_err = !fits(i_imm, 8);
            end
            ENC_OP_ADD, ENC_OP_SUB, ENC_OP_AND, ENC_OP_ORR: begin
                o_word = {i_op == ENC_OP_ADD ? OPC_ADD :
                          i_op == ENC_OP_SUB ? OPC_SUB :
                          i_op == ENC_OP_AND ? OPC_AND : OPC_ORR,
                          i_rm, 6'b0, i_rn, i_rd};
            end
            ENC_OP_CBZ: begin
                o_word      = {OPC_CBZ, i_imm[18:0], i_rd};
                o_range_err = !fits(i_imm, 18);
            end
            ENC_OP_B: begin
                o_word      = {OPC_B, i_imm[25:0]};
                o_range_err = !fits(i_imm, 25);
            end
            default: o_range_err = 1'b0;
        endcase
    end
endmodule

// File: rtl/inst_encoder.sv
// inst_encoder: registers encoded LEGv8 words with byte addresses, rejecting illegal descriptors
module inst_encoder import inst_encoder_pkg::*; #(
    parameter logic [63:0] BASE_ADDR = 64'h0,
    parameter int          ERR_CNT_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    inst_encoder_if.slave   bus
);
    logic                  r_valid;
    logic [INST_SIZE-1:0]  r_inst;
    logic [63:0]           r_addr;
    logic                  r_sticky;
    logic [ERR_CNT_W-1:0]  r_cnt;
    logic [INST_SIZE-1:0]  w_word;
    logic                  w_range_err;
    logic                  w_acc;
    logic                  w_xfer;
    logic                  w_rej;
    logic                  w_load;

    inst_field_pack u_pack (
        .i_op        (bus.in_op),
        .i_rd        (bus.in_rd),
        .i_rn        (bus.in_rn),
        .i_rm        (bus.in_rm),
        .i_imm       (bus.in_imm),
        .o_word      (w_word),
        .o_range_err (w_range_err)
    );

    assign bus.in_ready   = !r_valid || bus.out_ready;
    assign w_acc          = bus.in_valid && bus.in_ready;
    assign w_xfer         = r_valid && bus.out_ready;
    assign w_rej          = w_acc && (bus.in_op[3] || w_range_err);
    assign w_load         = w_acc && !w_rej;
    assign bus.out_valid  = r_valid;
    assign bus.out_inst   = r_inst;
    assign bus.out_addr   = r_addr;
    assign bus.err_sticky = r_sticky;
    assign bus.err_cnt    = r_cnt;

    // The address counts transfers, so it always labels the held or next loaded word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid  <= 1'b0;
            r_inst   <= '0;
            r_addr   <= BASE_ADDR;
            r_sticky <= 1'b0;
            r_cnt    <= '0;
        end else if (clr) begin
            r_valid  <= 1'b0;
            r_inst   <= '0;
            r_addr   <= BASE_ADDR;
            r_sticky <= 1'b0;
            r_cnt    <= '0;
        end else begin
            if (w_xfer)
                r_addr <= r_addr + 64'd4;
            if (w_load) begin
                r_valid <= 1'b1;
                r_inst  <= w_word;
            end else if (w_xfer)
                r_valid <= 1'b0;
            if (w_rej) begin
                r_sticky <= 1'b1;
                r_cnt    <= r_cnt + {{(ERR_CNT_W-1){1'b0}}, ~&r_cnt};
            end
        end
    end
endmodule
